// File: rtl/accel_dma_pkg.sv
// accel_dma_pkg: shared state encoding and packing constants for the DMA engine.
package accel_dma_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, FIN} state_e;
    localparam int LANES = 4;
endpackage

// File: rtl/accel_dma_byte_packer.sv
// byte_packer: gathers the low byte of result beats into little-endian words.
module byte_packer
    import accel_dma_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 valid_i,
    input  logic [7:0]           byte_i,
    output logic [DATA_SIZE-1:0] word_o,
    output logic                 full_o,
    output logic                 pend_o
);
    logic [1:0]           lane_q;
    logic [DATA_SIZE-1:0] acc_q;
    logic [DATA_SIZE-1:0] merged;

    // lanes above the current one are always zero, so OR-in is enough
    assign merged = acc_q | (DATA_SIZE'(byte_i) << {lane_q, 3'b000});
    assign full_o = valid_i && (lane_q == 2'(LANES - 1));
    assign pend_o = lane_q != 2'd0;
    assign word_o = valid_i ? merged : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (valid_i) begin
            lane_q <= lane_q + 2'd1;
            acc_q  <= full_o ? '0 : merged;
        end
    end
endmodule

// File: rtl/accel_dma.sv
// accel_dma: streams a memory block into the accelerator and writes its results
// back to memory, optionally packing four int8 results per word.
module accel_dma
    import accel_dma_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_base,
    input  logic [ADDR_W-1:0]    dst_base,
    input  logic [ADDR_W-1:0]    load_len,
    input  logic                 pack,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [DATA_SIZE-1:0] mem_wr_data,
    output logic                 acc_ready,
    output logic [DATA_SIZE-1:0] acc_data,
    input  logic                 acc_valid,
    input  logic [DATA_SIZE-1:0] acc_ofmap,
    input  logic                 acc_done,
    output logic                 busy,
    output logic                 irq,
    output logic [ADDR_W-1:0]    out_words
);
    state_e               state_q;
    logic [ADDR_W-1:0]    dst_q, rem_q, rd_addr_q, wr_addr_q, out_words_q;
    logic [DATA_SIZE-1:0] wr_data_q;
    logic                 pack_q, rd_en_q, ready_q, wr_en_q, busy_q, irq_q;
    logic                 capture, wr_now, accept;
    logic [DATA_SIZE-1:0] pk_word;
    logic                 pk_full, pk_pend;

    assign accept  = (state_q == IDLE) && start;
    assign capture = acc_valid && (state_q == LOAD || state_q == DRAIN);
    assign wr_now  = pack_q ? pk_full : capture;

    byte_packer #(.DATA_SIZE(DATA_SIZE)) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .valid_i (capture && pack_q),
        .byte_i  (acc_ofmap[7:0]),
        .word_o  (pk_word),
        .full_o  (pk_full),
        .pend_o  (pk_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dst_q       <= '0;
            rem_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            out_words_q <= '0;
            wr_data_q   <= '0;
            pack_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_q   <= 1'b0;
            wr_en_q <= 1'b0;
            ready_q <= rd_en_q;
            if (wr_now) begin
                wr_en_q     <= 1'b1;
                wr_addr_q   <= dst_q + out_words_q;
                wr_data_q   <= pack_q ? pk_word : acc_ofmap;
                out_words_q <= out_words_q + 1'b1;
            end
            case (state_q)
                IDLE: if (start) begin
                    dst_q       <= dst_base;
                    pack_q      <= pack;
                    out_words_q <= '0;
                    busy_q      <= 1'b1;
                    rd_en_q     <= load_len != '0;
                    rd_addr_q   <= src_base;
                    rem_q       <= load_len - 1'b1;
                    state_q     <= (load_len != '0) ? LOAD : DRAIN;
                end
                LOAD: if (rem_q != '0) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    rem_q     <= rem_q - 1'b1;
                end else begin
                    rd_en_q <= 1'b0;
                    state_q <= DRAIN;
                end
                DRAIN: if (acc_done) state_q <= FLUSH;
                FLUSH: begin
                    // partial word: unfilled upper lanes are already zero
                    if (pack_q && pk_pend) begin
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= dst_q + out_words_q;
                        wr_data_q   <= pk_word;
                        out_words_q <= out_words_q + 1'b1;
                    end
                    state_q <= FIN;
                end
                FIN: begin
                    irq_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign acc_ready   = ready_q;
    assign acc_data    = ready_q ? mem_rd_data : '0;
    assign busy        = busy_q;
    assign irq         = irq_q;
    assign out_words   = out_words_q;
endmodule

// File: tb/tb_accel_dma.sv
// tb_accel_dma: directed bench for accel_dma with a behavioural memory model.
module tb_accel_dma;
    logic        clk = 1'b0;
    logic        rst, start, pack, acc_valid, acc_done;
    logic [15:0] src_base, dst_base, load_len;
    logic        mem_rd_en, mem_wr_en, acc_ready, busy, irq;
    logic [15:0] mem_rd_addr, mem_wr_addr, out_words;
    logic [31:0] mem_rd_data, mem_wr_data, acc_data, acc_ofmap;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int irq_cnt = 0;
    logic [31:0] wmem [int];
    logic [31:0] rdy_log [$];
    int          rdy_cyc [$];
    logic [15:0] wa_log [$];
    logic [31:0] wd_log [$];

    always #5 clk = ~clk;

    accel_dma dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .load_len(load_len), .pack(pack), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_valid(acc_valid), .acc_ofmap(acc_ofmap), .acc_done(acc_done), .busy(busy),
        .irq(irq), .out_words(out_words)
    );

    // read contents: word at base+k (base 16-aligned) holds (k+1)*0x11
    function automatic logic [31:0] rd_pat(input logic [15:0] a);
        return (32'(a[3:0]) + 32'd1) * 32'h11;
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= rd_pat(mem_rd_addr);

    always @(negedge clk) begin
        cyc++;
        if (mem_wr_en) begin
            wmem[int'(mem_wr_addr)] = mem_wr_data;
            wa_log.push_back(mem_wr_addr);
            wd_log.push_back(mem_wr_data);
        end
        if (acc_ready) begin
            rdy_log.push_back(acc_data);
            rdy_cyc.push_back(cyc);
        end
        if (mem_rd_en) rd_cnt++;
        if (irq) irq_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input logic p);
        start = 1'b1; src_base = s; dst_base = d; load_len = l; pack = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic dn);
        acc_valid = v; acc_ofmap = d; acc_done = dn;
        @(negedge clk);
        acc_valid = 1'b0; acc_done = 1'b0;
    endtask

    initial begin
        int n0, w0, i0, r0;
        rst = 1'b1; start = 1'b0; pack = 1'b0; acc_valid = 1'b0; acc_done = 1'b0;
        src_base = '0; dst_base = '0; load_len = '0; acc_ofmap = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_ready", 32'(acc_ready), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_out_words", 32'(out_words), 0);
        chk("rst_acc_data", acc_data, 0);
        rst = 1'b0;
        tick();

        // basic load and unpacked readout
        n0 = rdy_log.size(); w0 = wa_log.size(); i0 = irq_cnt; r0 = rd_cnt;
        go(16'h0100, 16'h0300, 16'd5, 1'b0);
        chk("t1_first_rd", 32'(mem_rd_en), 1);
        chk("t1_rd_addr", 32'(mem_rd_addr), 32'h100);
        chk("t1_ready_late", 32'(acc_ready), 0);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_ready_first", 32'(acc_ready), 1);
        chk("t1_data_first", acc_data, 32'h11);
        repeat (5) tick();
        chk("t1_beats", 32'(rdy_log.size() - n0), 5);
        chk("t1_reads", 32'(rd_cnt - r0), 5);
        chk("t1_gapfree", 32'(rdy_cyc[n0 + 4] - rdy_cyc[n0]), 4);
        for (int k = 0; k < 5; k++) chk("t1_data", rdy_log[n0 + k], (32'(k) + 1) * 32'h11);
        beat(1'b1, 32'hA, 1'b0);
        chk("t1_wr_lat", 32'(mem_wr_en), 1);
        chk("t1_wr_addr0", 32'(mem_wr_addr), 32'h300);
        beat(1'b1, 32'hB, 1'b0);
        beat(1'b1, 32'hC, 1'b0);
        beat(1'b0, 32'h0, 1'b1);
        tick();
        chk("t1_irq_early", 32'(irq), 0);
        tick();
        chk("t1_irq_t3", 32'(irq), 1);
        chk("t1_busy_t3", 32'(busy), 0);
        tick();
        chk("t1_mem0", wmem[32'h300], 32'hA);
        chk("t1_mem1", wmem[32'h301], 32'hB);
        chk("t1_mem2", wmem[32'h302], 32'hC);
        chk("t1_out_words", 32'(out_words), 3);
        chk("t1_irq_once", 32'(irq_cnt - i0), 1);
        chk("t1_writes", 32'(wa_log.size() - w0), 3);

        // packing with partial flush
        w0 = wa_log.size();
        go(16'h0100, 16'h0400, 16'd0, 1'b1);
        for (int k = 1; k <= 4; k++) beat(1'b1, 32'hFFFFFF00 | 32'(k), 1'b0);
        chk("t2_full_wr", 32'(mem_wr_en), 1);
        chk("t2_full_data", mem_wr_data, 32'h04030201);
        beat(1'b1, 32'h5, 1'b0);
        beat(1'b1, 32'h6, 1'b0);
        beat(1'b0, 32'h0, 1'b1);
        tick();
        chk("t2_flush_wr", 32'(mem_wr_en), 1);
        chk("t2_flush_addr", 32'(mem_wr_addr), 32'h401);
        tick();
        chk("t2_irq", 32'(irq), 1);
        tick();
        chk("t2_mem0", wmem[32'h400], 32'h04030201);
        chk("t2_mem1", wmem[32'h401], 32'h00000605);
        chk("t2_out_words", 32'(out_words), 2);
        chk("t2_writes", 32'(wa_log.size() - w0), 2);

        // valid and done in the same cycle with lane 3 pending
        w0 = wa_log.size();
        go(16'h0100, 16'h0500, 16'd0, 1'b1);
        beat(1'b1, 32'h10, 1'b0);
        beat(1'b1, 32'h20, 1'b0);
        beat(1'b1, 32'h30, 1'b0);
        beat(1'b1, 32'h7F, 1'b1);
        chk("t3_wr", 32'(mem_wr_en), 1);
        chk("t3_data", mem_wr_data, 32'h7F302010);
        chk("t3_addr", 32'(mem_wr_addr), 32'h500);
        tick();
        chk("t3_no_flush", 32'(mem_wr_en), 0);
        tick();
        chk("t3_irq", 32'(irq), 1);
        tick();
        chk("t3_out_words", 32'(out_words), 1);
        chk("t3_writes", 32'(wa_log.size() - w0), 1);

        // empty load
        n0 = rdy_log.size(); w0 = wa_log.size(); i0 = irq_cnt; r0 = rd_cnt;
        go(16'h0100, 16'h0600, 16'd0, 1'b0);
        chk("t4_out_clear", 32'(out_words), 0);
        tick();
        beat(1'b0, 32'h0, 1'b1);
        tick();
        chk("t4_irq_t2", 32'(irq), 0);
        tick();
        chk("t4_irq_t3", 32'(irq), 1);
        chk("t4_busy_t3", 32'(busy), 0);
        tick();
        chk("t4_no_reads", 32'(rd_cnt - r0), 0);
        chk("t4_no_ready", 32'(rdy_log.size() - n0), 0);
        chk("t4_no_writes", 32'(wa_log.size() - w0), 0);
        chk("t4_out_words", 32'(out_words), 0);
        chk("t4_irq_once", 32'(irq_cnt - i0), 1);

        // write-address wrap
        w0 = wa_log.size();
        go(16'h0100, 16'hFFFF, 16'd0, 1'b0);
        beat(1'b1, 32'hDEAD, 1'b0);
        beat(1'b1, 32'hBEEF, 1'b0);
        beat(1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        chk("t5_writes", 32'(wa_log.size() - w0), 2);
        chk("t5_addr0", 32'(wa_log[w0]), 32'hFFFF);
        chk("t5_addr1", 32'(wa_log[w0 + 1]), 32'h0000);
        chk("t5_data1", wd_log[w0 + 1], 32'hBEEF);
        chk("t5_out_words", 32'(out_words), 2);

        // asynchronous reset mid-load, then a clean job
        i0 = irq_cnt;
        go(16'h0200, 16'h0700, 16'd8, 1'b0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rd_en", 32'(mem_rd_en), 0);
        chk("t6_ready", 32'(acc_ready), 0);
        chk("t6_acc_data", acc_data, 0);
        chk("t6_out_words", 32'(out_words), 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_no_irq", 32'(irq_cnt - i0), 0);
        n0 = rdy_log.size(); w0 = wa_log.size();
        go(16'h0200, 16'h0800, 16'd8, 1'b0);
        repeat (9) tick();
        chk("t6_beats", 32'(rdy_log.size() - n0), 8);
        for (int k = 0; k < 8; k++) chk("t6_data", rdy_log[n0 + k], (32'(k) + 1) * 32'h11);
        beat(1'b1, 32'h55AA, 1'b0);
        beat(1'b1, 32'hAA55, 1'b0);
        beat(1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        chk("t6_mem0", wmem[32'h800], 32'h55AA);
        chk("t6_mem1", wmem[32'h801], 32'hAA55);
        chk("t6_out_words", 32'(out_words), 2);
        chk("t6_irq", 32'(irq_cnt - i0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accel_dma.md
# accel_dma

Memory-side streaming engine on the opposite end of the accelerator's load/readout handshake. On `start` it reads a contiguous block of words from external memory and presents them to the accelerator's `ready`/`data_in` input. It then collects every `valid`/`ofmap` result word until the accelerator raises `done`, writing the results back to memory, optionally packed four int8 results per 32-bit word. It sits between the DRAM model (testbench or SoC bus) and the accelerator top.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `DATA_SIZE`, 32: data word width; packing assumes 32.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse; sampled only in IDLE.
- `src_base`, `dst_base`  in  ADDR_W: first read / first write word address; latched on accepted `start`.
- `load_len`  in  ADDR_W: number of words to stream in; latched on accepted `start`; 0 allowed.
- `pack`  in  1: 1 = pack low bytes of results 4-per-word; 0 = one result per word. Latched on accepted `start`.
- `mem_rd_en`  out  1, `mem_rd_addr`  out  ADDR_W, `mem_rd_data`  in  DATA_SIZE: read port, fixed 1-cycle latency.
- `mem_wr_en`  out  1, `mem_wr_addr`  out  ADDR_W, `mem_wr_data`  out  DATA_SIZE: write port, write occurs on the cycle `mem_wr_en` is high.
- `acc_ready`  out  1, `acc_data`  out  DATA_SIZE: word stream to the accelerator.
- `acc_valid`  in  1, `acc_ofmap`  in  DATA_SIZE, `acc_done`  in  1: result stream from the accelerator.
- `busy`  out  1: high from accepted `start` until return to IDLE.
- `irq`  out  1: one-cycle pulse on completion.
- `out_words`  out  ADDR_W: number of memory words written in the current or last job.

## Operation
- States are IDLE → LOAD → DRAIN → FLUSH → FIN → IDLE.
- **IDLE.** `start` latches configuration, clears `out_words` and the pack buffer, and sets `busy`.
  - If `load_len` ≠ 0, go to LOAD.
  - If `load_len` = 0, go to DRAIN.
- **LOAD.**
  - Issue `mem_rd_en` on `load_len` consecutive cycles at addresses `src_base`, `src_base`+1, … .
  - `acc_ready` is `mem_rd_en` delayed one cycle.
  - `acc_data` = `mem_rd_data` while `acc_ready` is high, otherwise 0.
  - After the last read is issued, go to DRAIN. The final `acc_ready` beat occurs in the first DRAIN cycle.
- **DRAIN.** Capture each `acc_valid` beat.
  - `pack` = 0: write `acc_ofmap` unchanged.
  - `pack` = 1: insert `acc_ofmap[7:0]` into byte lane `lane` (lane 0 = bits [7:0], little-endian). When lane 3 is filled, write the assembled word and reset `lane` to 0.
  - `acc_valid` is also accepted during LOAD; results are never dropped.
  - `acc_done` moves the block to FLUSH. A `valid` beat in the same cycle as `done` is captured first.
- **FLUSH.** If `pack` = 1 and `lane` ≠ 0, write the partial word with unused upper lanes zero. Otherwise perform no write.
- **FIN.** Pulse `irq`, drop `busy`, return to IDLE.
- Write address is `dst_base` + `out_words`. `out_words` increments on every write. Addresses wrap modulo 2^ADDR_W with no error.
- `start` while `busy` is ignored. `acc_valid` and `acc_done` in IDLE are ignored.

## Timing
- Reset values: every output is 0, the state is IDLE, and `lane` = 0.
- An asynchronous reset in any state aborts the job immediately, with no flush and no `irq`.
- Cycle after the `start` edge: the first `mem_rd_en`. The first `acc_ready` follows one cycle later.
- The load stream is gap-free: `load_len` consecutive `acc_ready` cycles.
- Result writes are registered. `mem_wr_en` is asserted one cycle after the `acc_valid` that completes a word (every beat when unpacked, every 4th beat when packed). The block sustains one write per cycle.
- `acc_done` at cycle t:
  - FLUSH write, if any, at t+2.
  - `irq` at t+3.
  - `busy` low at t+3.
- `mem_rd_en` and `mem_wr_en` may be high in the same cycle; the two ports are independent.

## Structure
- Shared package `accel_dma_pkg` holds the state enum (`IDLE`, `LOAD`, `DRAIN`, `FLUSH`, `FIN`) and the `LANES` = 4 constant.
- One natural sub-module: `byte_packer`, which holds lane counter, byte accumulation, the word-complete flag and partial flush. Everything else is a single FSM with address counters.

## Test plan
- **Basic load/readout.** `load_len` = 5, memory[src..src+4] = 0x11..0x55, `pack` = 0.
  - Required: five consecutive `acc_ready` beats carrying 0x11..0x55.
  - Then 3 valid beats 0xA, 0xB, 0xC and `done` → memory[dst..dst+2] = 0xA, 0xB, 0xC; `out_words` = 3; one `irq`.
- **Packing with partial flush.** `pack` = 1, valid bytes 0x01..0x06, then `done`.
  - Required: memory[dst] = 0x04030201, memory[dst+1] = 0x00000605, `out_words` = 2.
- **Same-cycle valid and done.** `acc_valid`=1 (0x7F) and `acc_done`=1 together in one cycle, `pack` = 1, lane = 3.
  - Required: the completed word is written, no extra flush write, `out_words` increments once.
- **Empty load.** `load_len` = 0.
  - Required: no `mem_rd_en` and no `acc_ready`. `done` with no results → no write, `irq` at t+3, `out_words` = 0.
- **Address wrap.** `dst_base` = 0xFFFF, 2 unpacked results.
  - Required: writes at 0xFFFF then 0x0000.
- **Reset mid-job.** Assert `rst` mid-LOAD after 2 of 8 beats.
  - Required: all outputs 0 immediately, no `irq`. A subsequent `start` runs a full clean job.
